systolic_mac_row: RTL and testbench



---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_mac_row_mac_pe.sv | 86 ++++++++
 rtl/systolic_mac_row.sv | 183 ++++++++++++++++++
 tb/tb_systolic_mac_row.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC row: FSM state encoding and
// accumulator range helpers used by the saturating PE build.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic longint acc_max(input int acc_w);
        return (longint'(1) <<< (acc_w - 1)) - 1;
    endfunction

    function automatic longint acc_min(input int acc_w);
        return -(longint'(1) <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/systolic_mac_row_mac_pe.sv
// One signed multiply-accumulate PE with result-valid flag.
// SYSTOLIC_SAT_EN selects clamping with a sticky overflow flag; otherwise the sum wraps.
module mac_pe
    import systolic_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_set_valid,
    input  logic                    i_en,
    input  logic                    i_last,
    input  logic signed [W-1:0]     i_a,
    input  logic signed [W-1:0]     i_w,
    output logic signed [ACC_W-1:0] o_acc,
    output logic                    o_valid,
    output logic                    o_ovf
);

    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_next;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_valid;

    assign w_prod = i_a * i_w;

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACC_W:0] LIM_MAX = (ACC_W+1)'(acc_max(ACC_W));
    localparam logic signed [ACC_W:0] LIM_MIN = (ACC_W+1)'(acc_min(ACC_W));

    logic signed [ACC_W:0] w_sum;
    logic                  w_clamp;
    logic                  r_ovf;

    // One guard bit is enough: both operands fit in ACC_W bits.
    assign w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod);

    always_comb begin
        w_next  = ACC_W'(w_sum);
        w_clamp = 1'b0;
        if (w_sum > LIM_MAX) begin
            w_next  = ACC_W'(LIM_MAX);
            w_clamp = 1'b1;
        end else if (w_sum < LIM_MIN) begin
            w_next  = ACC_W'(LIM_MIN);
            w_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_ovf <= 1'b0;
        end else if (i_en && w_clamp) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`else
    assign w_next = r_acc + ACC_W'(w_prod);
    assign o_ovf  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_valid <= i_set_valid;
        end else if (i_en) begin
            r_acc <= w_next;
            if (i_last) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_acc   = r_acc;
    assign o_valid = r_valid;

endmodule

// File: rtl/systolic_mac_row.sv
// Row of N_MACS MAC PEs fed by a skewed systolic pipeline with run-control FSM.
// Optional saturation: define SYSTOLIC_SAT_EN.
module systolic_mac_row
    import systolic_pkg::*;
#(
    parameter int  W      = 8,
    parameter int  ACC_W  = 16,
    parameter int  N_MACS = 4,
    parameter int  K_MAX  = 255,
    localparam int KW     = $clog2(K_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear_all,
    input  logic [KW-1:0]             k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [W-1:0]       in_a,
    input  logic [N_MACS*W-1:0]       in_w,
    output logic                      busy,
    output logic                      done,
    output logic [N_MACS*ACC_W-1:0]   acc_out,
    output logic [N_MACS-1:0]         valid_out,
    output logic [N_MACS-1:0]         ovf
);

    localparam int NS = (N_MACS > 1) ? N_MACS - 1 : 1;
    localparam int DW = (N_MACS > 2) ? $clog2(N_MACS) : 1;

    state_t        r_state;
    logic [KW-1:0] r_cnt;
    logic [DW-1:0] r_dcnt;
    logic          r_done;

    logic w_accept;
    logic w_last;
    logic w_start_ok;
    logic w_pe_clear;
    logic w_pe_set_valid;

    assign in_ready       = (r_state == ST_RUN) && (r_cnt != '0);
    assign w_accept       = in_valid && in_ready;
    assign w_last         = w_accept && (r_cnt == KW'(1));
    assign w_start_ok     = start && !clear_all && (r_state == ST_IDLE);
    assign w_pe_clear     = clear_all || w_start_ok;
    assign w_pe_set_valid = w_start_ok && (k_len == '0);
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear_all) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_dcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_cnt <= k_len;
                            if (k_len == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_accept) begin
                            r_cnt <= r_cnt - KW'(1);
                            if (r_cnt == KW'(1)) begin
                                if (N_MACS == 1) begin
                                    r_state <= ST_IDLE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= ST_DRAIN;
                                    r_dcnt  <= DW'(N_MACS - 2);
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Wait until the last beat has reached the final PE.
                        if (r_dcnt == '0) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt - DW'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Activation chain with per-stage valid and last-beat markers.
    logic signed [W-1:0] r_a [1:NS];
    logic                r_v [1:NS];
    logic                r_l [1:NS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 1; j <= NS; j++) begin
                r_a[j] <= '0;
                r_v[j] <= 1'b0;
                r_l[j] <= 1'b0;
            end
        end else begin
            r_a[1] <= in_a;
            r_v[1] <= w_accept && !clear_all;
            r_l[1] <= w_last && !clear_all;
            for (int j = 2; j <= NS; j++) begin
                r_a[j] <= r_a[j-1];
                r_v[j] <= r_v[j-1] && !clear_all;
                r_l[j] <= r_l[j-1] && !clear_all;
            end
        end
    end

    logic signed [W-1:0] w_pe_a [N_MACS];
    logic signed [W-1:0] w_pe_w [N_MACS];
    logic                w_pe_v [N_MACS];
    logic                w_pe_l [N_MACS];

    genvar gi;
    generate
        for (gi = 0; gi < N_MACS; gi++) begin : g_pe
            if (gi == 0) begin : g_direct
                assign w_pe_a[gi] = in_a;
                assign w_pe_w[gi] = in_w[gi*W +: W];
                assign w_pe_v[gi] = w_accept;
                assign w_pe_l[gi] = w_last;
            end else begin : g_skew
                // Lane gi weight delay line: gi stages, matching the activation skew.
                logic signed [W-1:0] r_wd [1:gi];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int s = 1; s <= gi; s++) begin
                            r_wd[s] <= '0;
                        end
                    end else begin
                        r_wd[1] <= in_w[gi*W +: W];
                        for (int s = 2; s <= gi; s++) begin
                            r_wd[s] <= r_wd[s-1];
                        end
                    end
                end

                assign w_pe_a[gi] = r_a[gi];
                assign w_pe_w[gi] = r_wd[gi];
                assign w_pe_v[gi] = r_v[gi];
                assign w_pe_l[gi] = r_l[gi];
            end

            mac_pe #(
                .W     (W),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .i_clear     (w_pe_clear),
                .i_set_valid (w_pe_set_valid),
                .i_en        (w_pe_v[gi]),
                .i_last      (w_pe_l[gi]),
                .i_a         (w_pe_a[gi]),
                .i_w         (w_pe_w[gi]),
                .o_acc       (acc_out[gi*ACC_W +: ACC_W]),
                .o_valid     (valid_out[gi]),
                .o_ovf       (ovf[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_systolic_mac_row.sv
// Self-checking bench for systolic_mac_row (N_MACS=4, W=8, ACC_W=16) against a sum-of-products model.
module tb_systolic_mac_row;

`ifdef SYSTOLIC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        clear_all = 1'b0;
    logic [7:0]  k_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [31:0] in_w = '0;
    logic        busy;
    logic        done;
    logic [63:0] acc_out;
    logic [3:0]  valid_out;
    logic [3:0]  ovf;

    systolic_mac_row #(.W(8), .ACC_W(16), .N_MACS(4), .K_MAX(255)) dut (
        .clk(clk), .rst(rst), .start(start), .clear_all(clear_all), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .busy(busy), .done(done), .acc_out(acc_out), .valid_out(valid_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int beat_a [16];
    int beat_w [16][4];
    logic [15:0] exp_acc [4];
    logic [3:0]  exp_ovf;
    int lat1, lat2, lat_tmp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: dot product per lane, clamped after every add when saturating.
    task automatic model(input int k);
        longint acc;
        longint lo, hi;
        lo = -32768;
        hi = 32767;
        exp_ovf = '0;
        for (int l = 0; l < 4; l++) begin
            acc = 0;
            for (int b = 0; b < k; b++) begin
                acc = acc + longint'(beat_a[b]) * longint'(beat_w[b][l]);
                if (SAT && acc > hi) begin acc = hi; exp_ovf[l] = 1'b1; end
                if (SAT && acc < lo) begin acc = lo; exp_ovf[l] = 1'b1; end
            end
            exp_acc[l] = acc[15:0];
        end
    endtask

    task automatic set_beats(input int k, input int a0, input int a1, input int a2,
                             input int w0, input int w1, input int w2, input int w3);
        int av [3];
        av = '{a0, a1, a2};
        for (int b = 0; b < k; b++) begin
            beat_a[b] = (b < 3) ? av[b] : a0;
            beat_w[b] = '{w0, w1, w2, w3};
        end
    endtask

    task automatic rand_beats(input int k);
        for (int b = 0; b < k; b++) begin
            beat_a[b] = int'($urandom_range(0, 255)) - 128;
            for (int l = 0; l < 4; l++) beat_w[b][l] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Drives one run of k>0 beats; stalls before beat index stall_at, or randomly.
    task automatic run(input int k, input int stall_at, input int nstall, input int spur_at,
                       input bit rand_stall, input bit b2b, output int lat);
        int start_edge, tl, idx, st, guard;
        bit v, acc_now;
        model(k);
        start = 1'b1;
        k_len = 8'(k);
        @(posedge clk);
        start_edge = cyc + 1;
        #1;
        start = 1'b0;
        check("rdy_rise", in_ready, 1);
        idx = 0; st = 0; guard = 0; tl = 0;
        while (idx < k && guard < 2000) begin
            guard++;
            if (rand_stall) v = ($urandom_range(0, 3) != 0);
            else if (idx == stall_at && st < nstall) begin v = 1'b0; st++; end
            else v = 1'b1;
            in_valid = v;
            in_a = 8'(beat_a[idx]);
            for (int l = 0; l < 4; l++) in_w[l*8 +: 8] = 8'(beat_w[idx][l]);
            if (idx == spur_at) begin start = 1'b1; k_len = 8'd9; end
            check("done_early", done, 0);
            acc_now = v && in_ready;
            tick();
            start = 1'b0;
            k_len = 8'(k);
            if (acc_now) begin
                idx++;
                if (idx == k) tl = cyc;
            end
        end
        in_valid = 1'b0;
        if (idx != k) check("beat_timeout", 64'(idx), 64'(k));
        for (int d = 0; d < 4; d++) begin
            if (d > 0) tick();
            check($sformatf("vout_d%0d", d), valid_out, 64'((1 << (d + 1)) - 1));
            check($sformatf("done_d%0d", d), done, 64'(d == 3));
            check($sformatf("busy_d%0d", d), busy, 64'(d < 3));
            check($sformatf("rdy_d%0d", d), in_ready, 0);
        end
        lat = cyc - start_edge;
        if (tl != 0) check("tl_latency", 64'(cyc - tl), 3);
        for (int l = 0; l < 4; l++) check($sformatf("acc%0d", l), acc_out[l*16 +: 16], exp_acc[l]);
        check("ovf", ovf, exp_ovf);
        if (!b2b) begin
            tick();
            check("done_once", done, 0);
            check("vout_hold", valid_out, 4'hF);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_acc", acc_out, 0);
        check("rst_vout", valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdy", in_ready, 0);
        check("rst_ovf", ovf, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic run
        set_beats(3, 1, 2, 3, 1, 2, -1, 0);
        run(3, -1, 0, -1, 1'b0, 1'b0, lat1);
        check("t1_acc", acc_out, {16'h0000, 16'hFFFA, 16'h000C, 16'h0006});
        check("t1_lat", 64'(lat1), 6);

        // Stalls after beat 1
        run(3, 1, 2, -1, 1'b0, 1'b0, lat2);
        check("t2_acc", acc_out, {16'h0000, 16'hFFFA, 16'h000C, 16'h0006});
        check("t2_lat", 64'(lat2), 64'(lat1 + 2));

        // Overflow
        set_beats(3, 127, 127, 127, 127, 127, 127, 127);
        run(3, -1, 0, -1, 1'b0, 1'b0, lat_tmp);
        if (SAT) begin
            check("t3_acc_sat", acc_out, {4{16'h7FFF}});
            check("t3_ovf_sat", ovf, 4'hF);
        end else begin
            check("t3_acc_wrap", acc_out, {4{16'hBD03}});
            check("t3_ovf_wrap", ovf, 4'h0);
        end

        // Abort mid-run
        set_beats(5, 3, -4, 5, 7, -2, 9, 1);
        start = 1'b1; k_len = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd3; in_w = {8'd1, 8'd9, 8'hFE, 8'd7};
        tick(); tick();
        in_valid = 1'b0;
        check("t4_pre_acc0", 64'(acc_out[15:0] != 0), 1);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("t4_acc", acc_out, 0);
        check("t4_vout", valid_out, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        tick();
        check("t4_done2", done, 0);
        check("t4_acc2", acc_out, 0);

        // start and clear_all together: nothing starts
        start = 1'b1; clear_all = 1'b1; k_len = 8'd2;
        tick();
        start = 1'b0; clear_all = 1'b0;
        check("t4_sc_busy", busy, 0);
        check("t4_sc_rdy", in_ready, 0);

        // Ignored start while busy
        set_beats(3, -5, 6, 7, 2, -3, 4, 11);
        run(3, -1, 0, 1, 1'b0, 1'b0, lat_tmp);
        check("t4_lat", 64'(lat_tmp), 6);

        // Zero length
        start = 1'b1; k_len = 8'd0;
        tick();
        start = 1'b0;
        check("t5_done", done, 1);
        check("t5_vout", valid_out, 4'hF);
        check("t5_acc", acc_out, 0);
        check("t5_rdy", in_ready, 0);
        check("t5_busy", busy, 0);
        tick();
        check("t5_done_off", done, 0);
        check("t5_rdy2", in_ready, 0);

        // Randomized runs, some back-to-back
        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(1, 10));
            rand_beats(k);
            run(k, -1, 0, -1, 1'b1, r[0], lat_tmp);
        end
        tick();

        // Reset asserted mid-DRAIN, between edges
        set_beats(2, 9, -9, 0, 4, 4, 4, 4);
        start = 1'b1; k_len = 8'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd9; in_w = {4{8'd4}};
        tick();
        in_a = 8'hF7;
        tick();
        in_valid = 1'b0;
        check("t6_in_drain", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_acc", acc_out, 0);
        check("t6_vout", valid_out, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        tick();
        set_beats(1, 2, 0, 0, 3, 3, 3, 3);
        run(1, -1, 0, -1, 1'b0, 1'b0, lat_tmp);
        check("t6_run_acc", acc_out, {4{16'd6}});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
